// File: rtl/wsi_pattern_source.sv
// WSI master that emits runs of fixed-length messages carrying a lane-indexed counting pattern.
// Supports zero-length messages, inter-message gaps, slave back-pressure and abort at message boundaries.
module wsi_pattern_source #(
  parameter int WSI_M0_DATAPATH_WIDTH = 32
) (
  input  logic                               wciS0_Clk,
  input  logic                               wciS0_MReset_n,
  input  logic                               start,
  input  logic                               abort,
  input  logic [11:0]                        msg_words,
  input  logic [15:0]                        msg_count,
  input  logic [7:0]                         gap_cycles,
  input  logic [7:0]                         opcode,
  output logic                               busy,
  output logic                               done,
  output logic [31:0]                        words_sent,
  output logic [2:0]                         wsiM0_MCmd,
  output logic                               wsiM0_MReqLast,
  output logic                               wsiM0_MBurstPrecise,
  output logic [11:0]                        wsiM0_MBurstLength,
  output logic [WSI_M0_DATAPATH_WIDTH-1:0]   wsiM0_MData,
  output logic [WSI_M0_DATAPATH_WIDTH/8-1:0] wsiM0_MByteEn,
  output logic [7:0]                         wsiM0_MReqInfo,
  input  logic                               wsiM0_SThreadBusy,
  output logic                               wsiM0_MReset_n,
  input  logic                               wsiM0_SReset_n
);

  localparam int DW    = WSI_M0_DATAPATH_WIDTH;
  localparam int LANES = DW / 32;
  localparam int BEW   = DW / 8;

  generate
    if (!(DW == 32 || DW == 64 || DW == 128 || DW == 256)) begin : g_bad_width
      $error("wsi_pattern_source: WSI_M0_DATAPATH_WIDTH must be 32, 64, 128 or 256");
    end
  endgenerate

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [2:0] CMD_IDLE = 3'h0;
  localparam logic [2:0] CMD_WR   = 3'h1;

  logic [1:0]      state_q, state_d;
  logic [11:0]     words_q, words_d;
  logic [15:0]     count_q, count_d;
  logic [7:0]      gap_q, gap_d;
  logic [7:0]      opcode_q, opcode_d;
  logic [11:0]     word_idx_q, word_idx_d;
  logic [15:0]     msg_idx_q, msg_idx_d;
  logic [7:0]      gap_cnt_q, gap_cnt_d;
  logic            abort_q, abort_d;
  logic [31:0]     pat_q, pat_d;
  logic [31:0]     words_sent_q, words_sent_d;
  logic [2:0]      mcmd_q, mcmd_d;
  logic            last_q, last_d;
  logic [11:0]     blen_q, blen_d;
  logic [DW-1:0]   data_q, data_d;
  logic [BEW-1:0]  be_q, be_d;
  logic [7:0]      info_q, info_d;

  logic [11:0]     burst_len;
  logic            zero_len;
  logic            last_word;
  logic            can_send;
  logic            abort_now;
  logic            msg_final;
  logic [31:0]     pat_base;
  logic [DW-1:0]   pattern_data;

  assign zero_len  = (words_q == 12'd0);
  assign burst_len = zero_len ? 12'd1 : words_q;
  assign last_word = (word_idx_q == burst_len - 12'd1);
  assign can_send  = !wsiM0_SThreadBusy && wsiM0_SReset_n;
  assign abort_now = abort_q || abort;
  assign msg_final = (count_q != 16'd0) && (msg_idx_q + 16'd1 == count_q);
  assign pat_base  = pat_q * 32'(LANES);

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign pattern_data[32*gi +: 32] = pat_base + 32'(gi);
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    words_d      = words_q;
    count_d      = count_q;
    gap_d        = gap_q;
    opcode_d     = opcode_q;
    word_idx_d   = word_idx_q;
    msg_idx_d    = msg_idx_q;
    gap_cnt_d    = gap_cnt_q;
    abort_d      = abort_q;
    pat_d        = pat_q;
    words_sent_d = words_sent_q;
    mcmd_d       = CMD_IDLE;
    last_d       = 1'b0;
    blen_d       = blen_q;
    data_d       = data_q;
    be_d         = '0;
    info_d       = info_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          words_d    = msg_words;
          count_d    = msg_count;
          gap_d      = gap_cycles;
          opcode_d   = opcode;
          word_idx_d = 12'd0;
          msg_idx_d  = 16'd0;
          abort_d    = 1'b0;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        if (abort) abort_d = 1'b1;
        // A message that has not started yet is itself a boundary, so abort may end the run here.
        if (word_idx_q == 12'd0 && abort_now) begin
          state_d = ST_DONE;
        end else if (can_send) begin
          mcmd_d       = CMD_WR;
          last_d       = last_word;
          blen_d       = burst_len;
          info_d       = opcode_q;
          data_d       = zero_len ? '0 : pattern_data;
          be_d         = zero_len ? '0 : '1;
          words_sent_d = words_sent_q + 32'd1;
          if (!zero_len) pat_d = pat_q + 32'd1;
          if (last_word) begin
            word_idx_d = 12'd0;
            msg_idx_d  = msg_idx_q + 16'd1;
            if (msg_final || abort_now) begin
              state_d = ST_DONE;
            end else if (gap_q != 8'd0) begin
              state_d   = ST_GAP;
              gap_cnt_d = gap_q;
            end
          end else begin
            word_idx_d = word_idx_q + 12'd1;
          end
        end
      end
      ST_GAP: begin
        if (abort) abort_d = 1'b1;
        if (gap_cnt_q <= 8'd1) state_d = ST_SEND;
        else gap_cnt_d = gap_cnt_q - 8'd1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wciS0_Clk or negedge wciS0_MReset_n) begin
    if (!wciS0_MReset_n) begin
      state_q      <= ST_IDLE;
      words_q      <= '0;
      count_q      <= '0;
      gap_q        <= '0;
      opcode_q     <= '0;
      word_idx_q   <= '0;
      msg_idx_q    <= '0;
      gap_cnt_q    <= '0;
      abort_q      <= 1'b0;
      pat_q        <= '0;
      words_sent_q <= '0;
      mcmd_q       <= CMD_IDLE;
      last_q       <= 1'b0;
      blen_q       <= '0;
      data_q       <= '0;
      be_q         <= '0;
      info_q       <= '0;
    end else begin
      state_q      <= state_d;
      words_q      <= words_d;
      count_q      <= count_d;
      gap_q        <= gap_d;
      opcode_q     <= opcode_d;
      word_idx_q   <= word_idx_d;
      msg_idx_q    <= msg_idx_d;
      gap_cnt_q    <= gap_cnt_d;
      abort_q      <= abort_d;
      pat_q        <= pat_d;
      words_sent_q <= words_sent_d;
      mcmd_q       <= mcmd_d;
      last_q       <= last_d;
      blen_q       <= blen_d;
      data_q       <= data_d;
      be_q         <= be_d;
      info_q       <= info_d;
    end
  end

  assign busy                = (state_q == ST_SEND) || (state_q == ST_GAP);
  assign done                = (state_q == ST_DONE);
  assign words_sent          = words_sent_q;
  assign wsiM0_MCmd          = mcmd_q;
  assign wsiM0_MReqLast      = last_q;
  assign wsiM0_MBurstPrecise = 1'b1;
  assign wsiM0_MBurstLength  = blen_q;
  assign wsiM0_MData         = data_q;
  assign wsiM0_MByteEn       = be_q;
  assign wsiM0_MReqInfo      = info_q;
  assign wsiM0_MReset_n      = wciS0_MReset_n;

endmodule

// File: tb/tb_wsi_pattern_source.sv
// Directed bench for wsi_pattern_source: a 32-bit and a 128-bit instance share one stimulus stream.
module tb_wsi_pattern_source;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, abort, sbusy, sreset_n;
  logic [11:0] msg_words;
  logic [15:0] msg_count;
  logic [7:0]  gap_cycles, opcode;

  logic        busy32, done32, last32, prec32, mrst32;
  logic [31:0] ws32, data32;
  logic [2:0]  mcmd32;
  logic [11:0] blen32;
  logic [3:0]  be32;
  logic [7:0]  info32;

  logic         busy128, done128, last128, prec128, mrst128;
  logic [31:0]  ws128;
  logic [127:0] data128;
  logic [2:0]   mcmd128;
  logic [11:0]  blen128;
  logic [15:0]  be128;
  logic [7:0]   info128;

  int checks = 0;
  int errors = 0;

  wsi_pattern_source #(.WSI_M0_DATAPATH_WIDTH(32)) dut32 (
    .wciS0_Clk(clk), .wciS0_MReset_n(rst_n), .start(start), .abort(abort),
    .msg_words(msg_words), .msg_count(msg_count), .gap_cycles(gap_cycles), .opcode(opcode),
    .busy(busy32), .done(done32), .words_sent(ws32),
    .wsiM0_MCmd(mcmd32), .wsiM0_MReqLast(last32), .wsiM0_MBurstPrecise(prec32),
    .wsiM0_MBurstLength(blen32), .wsiM0_MData(data32), .wsiM0_MByteEn(be32),
    .wsiM0_MReqInfo(info32), .wsiM0_SThreadBusy(sbusy), .wsiM0_MReset_n(mrst32),
    .wsiM0_SReset_n(sreset_n)
  );

  wsi_pattern_source #(.WSI_M0_DATAPATH_WIDTH(128)) dut128 (
    .wciS0_Clk(clk), .wciS0_MReset_n(rst_n), .start(start), .abort(abort),
    .msg_words(msg_words), .msg_count(msg_count), .gap_cycles(gap_cycles), .opcode(opcode),
    .busy(busy128), .done(done128), .words_sent(ws128),
    .wsiM0_MCmd(mcmd128), .wsiM0_MReqLast(last128), .wsiM0_MBurstPrecise(prec128),
    .wsiM0_MBurstLength(blen128), .wsiM0_MData(data128), .wsiM0_MByteEn(be128),
    .wsiM0_MReqInfo(info128), .wsiM0_SThreadBusy(sbusy), .wsiM0_MReset_n(mrst128),
    .wsiM0_SReset_n(sreset_n)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for the next WR word on the 32-bit instance; returns idle cycles seen first.
  task automatic wait_wr(input string tag, output int idle);
    idle = 0;
    @(negedge clk);
    while (mcmd32 !== 3'h1 && idle < 20) begin
      idle++;
      @(negedge clk);
    end
    check({tag, "_cmd"}, 128'(mcmd32), 128'(3'h1));
  endtask

  task automatic word(input string tag, input logic [31:0] d, input logic last,
                      input logic [3:0] be, input logic [11:0] blen, input logic [7:0] info,
                      input int exp_idle);
    int idle;
    wait_wr(tag, idle);
    check({tag, "_idle"}, 128'(idle), 128'(exp_idle));
    check({tag, "_data"}, 128'(data32), 128'(d));
    check({tag, "_last"}, 128'(last32), 128'(last));
    check({tag, "_be"},   128'(be32), 128'(be));
    check({tag, "_blen"}, 128'(blen32), 128'(blen));
    check({tag, "_info"}, 128'(info32), 128'(info));
    $display("word %s data=%0h last=%0b be=%0h idle_before=%0d", tag, data32, last32, be32, idle);
  endtask

  task automatic kick(input logic [11:0] w, input logic [15:0] c, input logic [7:0] g,
                      input logic [7:0] op);
    msg_words  = w;
    msg_count  = c;
    gap_cycles = g;
    opcode     = op;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_cmd"},   128'(mcmd32), 128'(0));
    check({tag, "_data"},  128'(data128), 128'(0));
    check({tag, "_last"},  128'(last32), 128'(0));
    check({tag, "_be"},    128'(be32), 128'(0));
    check({tag, "_blen"},  128'(blen32), 128'(0));
    check({tag, "_info"},  128'(info32), 128'(0));
    check({tag, "_prec"},  128'(prec32), 128'(1));
    check({tag, "_busy"},  128'(busy32), 128'(0));
    check({tag, "_done"},  128'(done32), 128'(0));
    check({tag, "_ws"},    128'(ws32), 128'(0));
    check({tag, "_mrst"},  128'(mrst32), 128'(0));
    $display("reset %s cmd=%0h ws=%0d busy=%0b", tag, mcmd32, ws32, busy32);
  endtask

  initial begin
    int wr_seen;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; sbusy = 1'b0; sreset_n = 1'b1;
    msg_words = '0; msg_count = '0; gap_cycles = '0; opcode = '0;

    repeat (2) @(negedge clk);
    check_reset("rst0");
    rst_n = 1'b1;
    @(negedge clk);
    check("rst0_mrst_rel", 128'(mrst32), 128'(1));

    // Two 4-word messages back to back; config inputs change after start and must be ignored.
    kick(12'd4, 16'd2, 8'd0, 8'hA5);
    msg_words = 12'd9;
    for (int i = 0; i < 8; i++) begin
      word($sformatf("s1_w%0d", i), 32'(i), (i % 4) == 3, 4'hF, 12'd4, 8'hA5, 0);
      if (i == 0) check("s1_busy", 128'(busy32), 128'(1));
    end
    check("s1_done", 128'(done32), 128'(1));
    check("s1_ws", 128'(ws32), 128'(8));
    @(negedge clk);
    check("s1_done_drop", 128'(done32), 128'(0));
    check("s1_busy_drop", 128'(busy32), 128'(0));
    check("s1_cmd_idle", 128'(mcmd32), 128'(0));

    rst_n = 1'b0;
    #1;
    check_reset("rst1");
    @(negedge clk);
    rst_n = 1'b1;

    // 128-bit lanes: pat*4+k per lane.
    kick(12'd2, 16'd1, 8'd0, 8'h3C);
    word("s2_w0", 32'd0, 1'b0, 4'hF, 12'd2, 8'h3C, 0);
    check("s2_w0_d128", data128, {32'd3, 32'd2, 32'd1, 32'd0});
    check("s2_w0_be128", 128'(be128), 128'(16'hFFFF));
    word("s2_w1", 32'd1, 1'b1, 4'hF, 12'd2, 8'h3C, 0);
    check("s2_w1_d128", data128, {32'd7, 32'd6, 32'd5, 32'd4});
    check("s2_w1_last128", 128'(last128), 128'(1));
    check("s2_done", 128'(done128), 128'(1));
    @(negedge clk);

    // Back-pressure for 3 cycles before word 2.
    kick(12'd4, 16'd1, 8'd0, 8'h11);
    word("s3_w0", 32'd2, 1'b0, 4'hF, 12'd4, 8'h11, 0);
    word("s3_w1", 32'd3, 1'b0, 4'hF, 12'd4, 8'h11, 0);
    sbusy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("s3_stall%0d", i), 128'(mcmd32), 128'(0));
    end
    sbusy = 1'b0;
    word("s3_w2", 32'd4, 1'b0, 4'hF, 12'd4, 8'h11, 0);
    word("s3_w3", 32'd5, 1'b1, 4'hF, 12'd4, 8'h11, 0);
    check("s3_ws", 128'(ws32), 128'(6));
    @(negedge clk);

    // Zero-length messages with a 2-cycle gap.
    kick(12'd0, 16'd3, 8'd2, 8'h22);
    word("s4_w0", 32'd0, 1'b1, 4'h0, 12'd1, 8'h22, 0);
    word("s4_w1", 32'd0, 1'b1, 4'h0, 12'd1, 8'h22, 2);
    word("s4_w2", 32'd0, 1'b1, 4'h0, 12'd1, 8'h22, 2);
    check("s4_done", 128'(done32), 128'(1));
    check("s4_ws", 128'(ws32), 128'(9));
    @(negedge clk);

    // Endless run, aborted during word 1: message completes, then DONE.
    kick(12'd5, 16'd0, 8'd0, 8'h33);
    word("s5_w0", 32'd6, 1'b0, 4'hF, 12'd5, 8'h33, 0);
    word("s5_w1", 32'd7, 1'b0, 4'hF, 12'd5, 8'h33, 0);
    abort = 1'b1;
    word("s5_w2", 32'd8, 1'b0, 4'hF, 12'd5, 8'h33, 0);
    abort = 1'b0;
    word("s5_w3", 32'd9, 1'b0, 4'hF, 12'd5, 8'h33, 0);
    word("s5_w4", 32'd10, 1'b1, 4'hF, 12'd5, 8'h33, 0);
    check("s5_done", 128'(done32), 128'(1));
    @(negedge clk);
    check("s5_busy", 128'(busy32), 128'(0));
    wr_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (mcmd32 === 3'h1) wr_seen++;
    end
    check("s5_no_wr", 128'(wr_seen), 128'(0));

    // Reset in the middle of a message.
    kick(12'd4, 16'd1, 8'd0, 8'h44);
    word("s6_w0", 32'd11, 1'b0, 4'hF, 12'd4, 8'h44, 0);
    word("s6_w1", 32'd12, 1'b0, 4'hF, 12'd4, 8'h44, 0);
    word("s6_w2", 32'd13, 1'b0, 4'hF, 12'd4, 8'h44, 0);
    rst_n = 1'b0;
    #1;
    check_reset("rst2");
    @(negedge clk);
    rst_n = 1'b1;
    wr_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (mcmd32 === 3'h1) wr_seen++;
    end
    check("s6_no_wr", 128'(wr_seen), 128'(0));
    kick(12'd1, 16'd1, 8'd0, 8'h55);
    word("s6_new", 32'd0, 1'b1, 4'hF, 12'd1, 8'h55, 0);
    check("s6_ws", 128'(ws32), 128'(1));
    check("s6_done", 128'(done32), 128'(1));
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
